// File: rtl/dp_vram.sv
// Parametrised true dual-port video RAM with byte enables, collision/range flags and a clear engine.
// Optional macro DP_VRAM_OUT_REG_EN adds one output register stage per port (2-cycle read latency).
module dp_vram #(
  parameter int                DATA_W         = 32,
  parameter int                DEPTH          = 2048,
  parameter int                ADDR_W         = $clog2(DEPTH),
  parameter int                RD_MODE        = 0,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0,
  parameter int                CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  busy,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_rvalid,
  output logic                  collision,
  output logic                  addr_err
);

  localparam int              NB      = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e              state_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                a_in, b_in, a_acc, b_acc, a_wr, b_wr;
  logic [DATA_W-1:0]   a_old, b_old;
  logic [DATA_W-1:0]   a_rdata_d, b_rdata_d, a_rdata_q, b_rdata_q;
  logic                a_rvalid_d, b_rvalid_d, collision_d, addr_err_d;
  logic                a_rvalid_q, b_rvalid_q, collision_q, addr_err_q;

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // Clear engine: sweeps every address once, one word per cycle; clear_req is ignored while sweeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      busy_q    <= (CLEAR_ON_RESET != 0);
      clr_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            state_q   <= S_CLEAR;
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == LAST_C) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign a_in  = ({1'b0, a_addr} < DEPTH_C);
  assign b_in  = ({1'b0, b_addr} < DEPTH_C);
  assign a_acc = a_en & ~busy_q;
  assign b_acc = b_en & ~busy_q;
  assign a_wr  = a_acc & a_we & a_in;
  assign b_wr  = b_acc & b_we & b_in;
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  // Port A writes are applied after port B so A owns any lane both ports enable.
  always_ff @(posedge clk) begin
    if (busy_q) begin
      mem[clr_cnt_q] <= CLEAR_VALUE;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_wr && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
        if (a_wr && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_acc) begin
      if (!a_in)                     a_rdata_d = '0;
      else if (RD_MODE == 1 && a_we) a_rdata_d = lane_merge(a_old, a_wdata, a_be);
      else                           a_rdata_d = a_old;
    end
    if (b_acc) begin
      if (!b_in)                     b_rdata_d = '0;
      else if (RD_MODE == 1 && b_we) b_rdata_d = lane_merge(b_old, b_wdata, b_be);
      else                           b_rdata_d = b_old;
    end
  end

  assign a_rvalid_d  = a_acc;
  assign b_rvalid_d  = b_acc;
  assign collision_d = a_wr & b_wr & (a_addr == b_addr);
  assign addr_err_d  = (a_acc & ~a_in) | (b_acc & ~b_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      collision_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      a_rvalid_q  <= a_rvalid_d;
      b_rvalid_q  <= b_rvalid_d;
      collision_q <= collision_d;
      addr_err_q  <= addr_err_d;
    end
  end

`ifdef DP_VRAM_OUT_REG_EN
  logic [DATA_W-1:0] a_rdata_q2, b_rdata_q2;
  logic              a_rvalid_q2, b_rvalid_q2, collision_q2, addr_err_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata_q2   <= '0;
      b_rdata_q2   <= '0;
      a_rvalid_q2  <= 1'b0;
      b_rvalid_q2  <= 1'b0;
      collision_q2 <= 1'b0;
      addr_err_q2  <= 1'b0;
    end else begin
      a_rdata_q2   <= a_rdata_q;
      b_rdata_q2   <= b_rdata_q;
      a_rvalid_q2  <= a_rvalid_q;
      b_rvalid_q2  <= b_rvalid_q;
      collision_q2 <= collision_q;
      addr_err_q2  <= addr_err_q;
    end
  end

  assign a_rdata   = a_rdata_q2;
  assign b_rdata   = b_rdata_q2;
  assign a_rvalid  = a_rvalid_q2;
  assign b_rvalid  = b_rvalid_q2;
  assign collision = collision_q2;
  assign addr_err  = addr_err_q2;
`else
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign collision = collision_q;
  assign addr_err  = addr_err_q;
`endif

endmodule

// File: tb/tb_dp_vram.sv
// Bench for dp_vram: a read-first and a write-first instance share stimulus and are checked
// against a word-array reference model.
module tb_dp_vram;

  localparam int          DEPTH = 300;
  localparam int          AW    = 9;
  localparam logic [31:0] CV0   = 32'h0000_0000;
  localparam logic [31:0] CV1   = 32'hC3C3_3C3C;
`ifdef DP_VRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_req;
  logic          a_en, a_we, b_en, b_we;
  logic [3:0]    a_be, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wdata, b_wdata;
  logic [31:0]   a_rdata0, b_rdata0, a_rdata1, b_rdata1;
  logic          busy0, busy1, a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1;
  logic          collision0, collision1, addr_err0, addr_err1;

  always #5 clk = ~clk;

  dp_vram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .RD_MODE(0),
            .CLEAR_VALUE(CV0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata0), .a_rvalid(a_rvalid0),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata0), .b_rvalid(b_rvalid0),
    .collision(collision0), .addr_err(addr_err0));

  dp_vram #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(AW), .RD_MODE(1),
            .CLEAR_VALUE(CV1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
    .b_en(b_en), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
    .collision(collision1), .addr_err(addr_err1));

  typedef struct packed {
    logic [31:0] ar0, ar1, br0, br1;
    logic        av, bv, coll, err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl0 [DEPTH];
  logic [31:0] mdl1 [DEPTH];
  logic [31:0] last_a0, last_a1, last_b0, last_b1;
  int          busy_left;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, want);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_a0 = '0; last_a1 = '0; last_b0 = '0; last_b1 = '0;
    busy_left = DEPTH;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;
    clear_req = 1'b0;
  endtask

  task automatic set_a(input logic we, input logic [3:0] be, input int addr, input logic [31:0] d);
    a_en = 1'b1; a_we = we; a_be = be; a_addr = AW'(addr); a_wdata = d;
  endtask

  task automatic set_b(input logic we, input logic [3:0] be, input int addr, input logic [31:0] d);
    b_en = 1'b1; b_we = we; b_be = be; b_addr = AW'(addr); b_wdata = d;
  endtask

  task automatic rand_ops(input bit allow_clear);
    a_en = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
    b_en = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
    a_be = 4'($urandom); b_be = 4'($urandom);
    a_wdata = $urandom; b_wdata = $urandom;
    a_addr = ($urandom % 8 == 0) ? AW'($urandom_range(295, 311)) : AW'($urandom_range(0, 15));
    b_addr = ($urandom % 8 == 0) ? AW'($urandom_range(295, 311)) : AW'($urandom_range(0, 15));
    clear_req = allow_clear && ($urandom % 150 == 0);
  endtask

  // One clock: predict this cycle's outcome, update the model, then compare what is due.
  task automatic step();
    exp_t e;
    bit   a_in, b_in;
    e = '0;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          mdl0[i] = CV0;
          mdl1[i] = CV1;
        end
      end
    end else begin
      a_in   = (int'(a_addr) < DEPTH);
      b_in   = (int'(b_addr) < DEPTH);
      e.av   = a_en;
      e.bv   = b_en;
      e.err  = (a_en && !a_in) || (b_en && !b_in);
      e.coll = a_en && b_en && a_we && b_we && a_in && b_in && (a_addr == b_addr);
      if (a_en) begin
        last_a0 = a_in ? mdl0[a_addr] : '0;
        last_a1 = !a_in ? '0 : (a_we ? merge(mdl1[a_addr], a_wdata, a_be) : mdl1[a_addr]);
      end
      if (b_en) begin
        last_b0 = b_in ? mdl0[b_addr] : '0;
        last_b1 = !b_in ? '0 : (b_we ? merge(mdl1[b_addr], b_wdata, b_be) : mdl1[b_addr]);
      end
      if (b_en && b_we && b_in) begin
        mdl0[b_addr] = merge(mdl0[b_addr], b_wdata, b_be);
        mdl1[b_addr] = merge(mdl1[b_addr], b_wdata, b_be);
      end
      if (a_en && a_we && a_in) begin
        mdl0[a_addr] = merge(mdl0[a_addr], a_wdata, a_be);
        mdl1[a_addr] = merge(mdl1[a_addr], a_wdata, a_be);
      end
      if (clear_req) busy_left = DEPTH;
    end
    e.ar0 = last_a0; e.ar1 = last_a1; e.br0 = last_b0; e.br1 = last_b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_eq("busy0", 32'(busy0), 32'(busy_left > 0));
    check_eq("busy1", 32'(busy1), 32'(busy_left > 0));
    if (exp_q.size() >= LAT) begin
      e = exp_q.pop_front();
      check_eq("a_rdata0",   a_rdata0, e.ar0);
      check_eq("a_rdata1",   a_rdata1, e.ar1);
      check_eq("b_rdata0",   b_rdata0, e.br0);
      check_eq("b_rdata1",   b_rdata1, e.br1);
      check_eq("a_rvalid",   {30'b0, a_rvalid1, a_rvalid0},   {30'b0, e.av, e.av});
      check_eq("b_rvalid",   {30'b0, b_rvalid1, b_rvalid0},   {30'b0, e.bv, e.bv});
      check_eq("collision",  {30'b0, collision1, collision0}, {30'b0, e.coll, e.coll});
      check_eq("addr_err",   {30'b0, addr_err1, addr_err0},   {30'b0, e.err, e.err});
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_a_rdata", a_rdata0 | a_rdata1, 32'h0);
    check_eq("rst_b_rdata", b_rdata0 | b_rdata1, 32'h0);
    check_eq("rst_flags", {26'b0, a_rvalid0, b_rvalid0, a_rvalid1, b_rvalid1,
                           collision0 | collision1, addr_err0 | addr_err1}, 32'h0);
    check_eq("rst_busy", {30'b0, busy1, busy0}, 32'h3);
  endtask

  // Counts cycles with busy high; port traffic is optionally sprayed to prove it is ignored.
  task automatic measure_busy(input bit traffic);
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < 400) begin
      n++;
      if (traffic) rand_ops(1'b0);
      else idle();
      step();
    end
    idle();
    check_eq("busy_len", 32'(n), 32'(DEPTH));
  endtask

  initial begin
    int c;
    idle();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    measure_busy(1'b0);

    set_a(1'b0, 4'h0, 0, '0); set_b(1'b0, 4'h0, 299, '0); step();
    idle(); step();
    check_eq("clr_rd0",   a_rdata0, 32'h0);
    check_eq("clr_rd299", b_rdata0, 32'h0);
    check_eq("clr_cv1",   a_rdata1, CV1);

    set_a(1'b1, 4'hF, 5, 32'hDEAD_BEEF); step();
    set_a(1'b1, 4'h5, 5, 32'h1122_3344); step();
    idle(); set_b(1'b0, 4'h0, 5, '0); step();
    idle(); step();
    check_eq("byte_lanes", b_rdata0, 32'hDE22_BE44);

    set_a(1'b1, 4'hF, 7, 32'h5555_5555); step();
    set_a(1'b1, 4'hF, 7, 32'hAAAA_AAAA); step();
    idle(); step();
    check_eq("rdw_mode0", a_rdata0, 32'h5555_5555);
    check_eq("rdw_mode1", a_rdata1, 32'hAAAA_AAAA);

    set_a(1'b1, 4'b0001, 9, 32'h0000_00FF); set_b(1'b1, 4'b0011, 9, 32'h0000_FF00); step();
    c = 0;
    repeat (3) begin
      c += int'(collision0);
      idle(); step();
    end
    check_eq("coll_pulses", 32'(c), 32'd1);
    set_a(1'b0, 4'h0, 9, '0); step();
    idle(); step();
    check_eq("coll_merge", a_rdata0, 32'h0000_FFFF);

    set_b(1'b1, 4'hF, 300, 32'h1234_5678); step();
    idle(); set_b(1'b0, 4'h0, 300, '0); step();
    idle(); step();
    check_eq("oor_rdata", b_rdata0, 32'h0);
    set_b(1'b0, 4'h0, 299, '0); step();
    idle(); step();
    check_eq("oor_299", b_rdata1, CV1);

    repeat (600) begin
      rand_ops(1'b1);
      step();
    end
    idle();
    while (busy_left > 0) step();

    clear_req = 1'b1; step();
    clear_req = 1'b0;
    repeat (150) begin
      rand_ops(1'b0);
      step();
    end
    idle();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    measure_busy(1'b1);

    for (int i = 0; i < DEPTH; i++) begin
      set_a(1'b0, 4'h0, i, '0);
      set_b(1'b0, 4'h0, DEPTH - 1 - i, '0);
      step();
    end
    idle();
    repeat (LAT) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dp_vram.md
Name: dp_vram

Overview:
- Parametrised true dual-port synchronous RAM for the video subsystem.
- Generalised successor to the fixed-size tile, sprite, palette and OAM stores; one body instantiated at any width and depth.
- Adds over the fixed stores:
  - per-lane byte enables
  - selectable same-port read-during-write mode
  - defined cross-port collision resolution
  - out-of-range address detection
  - hardware clear engine that fills memory after reset or on request

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
DEPTH, 2048, number of words; need not be a power of two (e.g. 300)
ADDR_W, $clog2(DEPTH), address width
RD_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
CLEAR_VALUE, 0, word written to every entry by the clear engine
CLEAR_ON_RESET, 1, 1 = clear engine starts automatically when reset deasserts

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous active-high reset
clear_req  input  1  one-cycle pulse starts a full clear
busy  output  1  high while clear engine runs
a_en  input  1  port A access enable
a_we  input  1  port A write (1) / read (0)
a_be  input  DATA_W/8  port A byte-lane write enables
a_addr  input  ADDR_W  port A word address
a_wdata  input  DATA_W  port A write data
a_rdata  output  DATA_W  port A read data
a_rvalid  output  1  port A read data valid pulse
b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid  as port A, for port B
collision  output  1  both ports wrote the same address
addr_err  output  1  an enabled access used addr >= DEPTH

Behaviour:
- Reset: asserted asynchronously; clock and reset named clk and reset.
  - Reset values: a_rdata = b_rdata = 0; a_rvalid = b_rvalid = 0; collision = 0; addr_err = 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET = 1, else IDLE. busy = CLEAR_ON_RESET.
  - Array contents are not reset.
- FSM states:
  - IDLE to CLEAR on clear_req.
  - In CLEAR, a counter writes CLEAR_VALUE to address 0..DEPTH-1, one word per cycle.
  - CLEAR to IDLE after address DEPTH-1 is written.
  - busy is high for exactly DEPTH cycles.
  - clear_req during CLEAR is ignored.
  - Reset mid-clear restarts the clear from address 0.
- While busy:
  - Port enables are ignored: no writes, rvalid stays 0, addr_err stays 0.
  - rdata holds its value.
- Read:
  - Enabled read with a_we = 0: rdata updates and rvalid pulses for exactly 1 cycle, 1 cycle after the request.
  - rdata holds its last value when no read is issued.
- Write:
  - Only lanes with be[i] = 1 update bits [8i+7:8i].
  - a_we = 1 with be = 0 writes nothing.
- Write with simultaneous read output: a write also produces rdata/rvalid.
  - RD_MODE = 0: old word.
  - RD_MODE = 1: old word merged with wdata per be.
- Cross-port rules:
  - A writes while B reads the same address in the same cycle: B returns the old word.
  - Symmetric for B writing / A reading.
  - Both ports write the same address in the same cycle: port A wins on lanes both enable; each port's exclusive lanes are applied.
  - collision pulses 1 cycle later, aligned with rvalid, whether or not the be sets overlap.
- Out of range: an enabled access with addr >= DEPTH:
  - write is dropped
  - read returns rdata = 0 with rvalid = 1
  - addr_err pulses 1 cycle later
  - the two ports are OR-ed into addr_err

Optional Feature:
- Macro: DP_VRAM_OUT_REG_EN
- Defined:
  - An extra output register stage on each port: rdata, rvalid, collision and addr_err all arrive 2 cycles after the request.
  - The extra stage is reset to 0.
  - Throughput stays one access per port per cycle.
- Undefined: latency is 1 cycle as above.
- The test plan latencies below assume the macro is undefined; add 1 cycle if defined.

Test Plan:
- Reset, DEPTH = 300, CLEAR_ON_RESET = 1 -> busy high for exactly 300 cycles; afterwards A read of addr 0 and addr 299 returns 0x00000000 with rvalid 1 cycle later.
- A writes 0xDEADBEEF to addr 5 with be = 4'b1111, then 0x11223344 with be = 4'b0101; B reads addr 5 -> 0xDE22BE44.
- RD_MODE = 0 vs 1, A writes 0xAAAAAAAA over 0x55555555 at addr 7 in one cycle -> a_rdata 0x55555555 (mode 0) / 0xAAAAAAAA (mode 1).
- Same cycle, A writes 0x000000FF with be = 4'b0001 and B writes 0x0000FF00 with be = 4'b0011 to addr 9 -> collision pulses once; a later read returns 0x0000FFFF.
- DEPTH = 300: B writes addr 300, then B reads addr 300 -> write dropped, rdata 0, addr_err pulses on both accesses; addr 299 unchanged.
- Assert clear_req, then assert reset halfway through the clear -> after reset busy lasts a full DEPTH cycles; all entries read CLEAR_VALUE; port accesses issued during busy give no rvalid.
